// File: rtl/fb_pkg.sv
// Shared types and widths for the PSRAM framebuffer write path.
package fb_pkg;
  localparam int FB_ADDR_W = 26;
  localparam int FB_DATA_W = 16;
  localparam int FB_WORD_W = FB_ADDR_W + FB_DATA_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP, CLEAR} state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
    logic                 last;
  } fb_word_t;
endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous word FIFO with full/empty flags; storage is not reset, only the pointers.
module fb_word_fifo
  import fb_pkg::*;
#(
  parameter int WIDTH = FB_WORD_W,
  parameter int DEPTH = 8
) (
  input  logic             clk_100mhz,
  input  logic             n_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]     wptr;
  logic [PTR_W:0]     rptr;
  logic [WIDTH-1:0]   mem [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign pop_data = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk_100mhz or negedge n_reset) begin
    if (!n_reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (push && !full) mem[wptr[PTR_W-1:0]] <= push_data;
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// Packs raster RGB332 pixels into 16-bit words and writes them to PSRAM one word at a time.
// Optional frame clear is compiled in with FB_CLEAR_EN.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int                   H_RES      = 640,
  parameter int                   V_RES      = 480,
  parameter logic [FB_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                   FIFO_DEPTH = 8
) (
  input  logic                 clk_100mhz,
  input  logic                 n_reset,
  input  logic                 pix_valid_i,
  output logic                 pix_ready_o,
  input  logic [7:0]           pix_data_i,
  input  logic                 pix_sof_i,
  output logic                 ram_cs_o,
  output logic                 ram_rnw_o,
  output logic [FB_ADDR_W-1:0] ram_addr_o,
  output logic [FB_DATA_W-1:0] ram_wdata_o,
  input  logic                 ram_ready_i,
  output logic                 busy_o,
  output logic                 frame_done_o
`ifdef FB_CLEAR_EN
  ,
  input  logic                 clear_i,
  input  logic [7:0]           clear_color_i
`endif
);
  localparam int N_PIX   = H_RES * V_RES;
  localparam int N_WORDS = N_PIX / 2;
  localparam int IDX_W   = $clog2(N_PIX);

  function automatic logic [FB_ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + FB_ADDR_W'(idx >> 1);
  endfunction

  state_t           state;
  logic             ready_en;
  logic [IDX_W-1:0] pix_idx;
  logic [IDX_W-1:0] cur_idx;
  logic [7:0]       half_pix;
  logic             pix_fire;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  fb_word_t         push_word;
  fb_word_t         head;
  logic             cur_last;
  logic             clearing;
  logic             clr_start;
  logic             clr_done;

  assign pix_ready_o = ready_en && !fifo_full && !clearing && (state != CLEAR);
  assign pix_fire    = pix_valid_i && pix_ready_o;
  assign cur_idx     = pix_sof_i ? '0 : pix_idx;
  assign push        = pix_fire && cur_idx[0];
  assign ram_rnw_o   = 1'b0;
  assign busy_o      = !fifo_empty || (state != IDLE) || clearing;
  assign clr_done    = (state == GAP) && clearing && cur_last;
  assign pop         = (state == IDLE) && !fifo_empty && !clr_start;

`ifdef FB_CLEAR_EN
  localparam int CLR_W = $clog2(N_WORDS);
  logic [CLR_W-1:0] clr_cnt;
  assign clr_start = (state == IDLE) && clear_i && fifo_empty;
`else
  assign clr_start = 1'b0;
`endif

  always_comb begin
    push_word      = '0;
    push_word.addr = word_addr(cur_idx);
    push_word.data = {pix_data_i, half_pix};
    push_word.last = (cur_idx == IDX_W'(N_PIX - 1));
  end

  fb_word_fifo #(
    .WIDTH (FB_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100mhz (clk_100mhz),
    .n_reset    (n_reset),
    .push       (push),
    .push_data  (push_word),
    .pop        (pop),
    .pop_data   (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Packer: even pixels wait in the half-word latch, odd pixels complete a FIFO word.
  always_ff @(posedge clk_100mhz or negedge n_reset) begin
    if (!n_reset) begin
      ready_en <= 1'b0;
      pix_idx  <= '0;
      half_pix <= '0;
    end else begin
      ready_en <= 1'b1;
      if (clr_done) begin
        pix_idx  <= '0;
        half_pix <= '0;
      end else if (pix_fire) begin
        pix_idx <= (cur_idx == IDX_W'(N_PIX - 1)) ? '0 : cur_idx + 1'b1;
        if (!cur_idx[0]) half_pix <= pix_data_i;
      end
    end
  end

  // Request FSM: IDLE/CLEAR load a word, REQ holds it until ready, GAP enforces spacing.
  always_ff @(posedge clk_100mhz or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      ram_cs_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_wdata_o  <= '0;
      cur_last     <= 1'b0;
      frame_done_o <= 1'b0;
      clearing     <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt      <= '0;
`endif
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
`ifdef FB_CLEAR_EN
          if (clr_start) begin
            state    <= CLEAR;
            clearing <= 1'b1;
            clr_cnt  <= '0;
          end else
`endif
          if (!fifo_empty) begin
            ram_addr_o  <= head.addr;
            ram_wdata_o <= head.data;
            cur_last    <= head.last;
            ram_cs_o    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (ram_ready_i) begin
            ram_cs_o     <= 1'b0;
            frame_done_o <= cur_last;
            state        <= GAP;
          end
        end
        GAP: begin
          if (clearing && !cur_last) begin
            state <= CLEAR;
          end else begin
            state    <= IDLE;
            clearing <= 1'b0;
          end
        end
`ifdef FB_CLEAR_EN
        CLEAR: begin
          ram_addr_o  <= BASE_ADDR + FB_ADDR_W'(clr_cnt);
          ram_wdata_o <= {clear_color_i, clear_color_i};
          cur_last    <= (clr_cnt == CLR_W'(N_WORDS - 1));
          clr_cnt     <= clr_cnt + 1'b1;
          ram_cs_o    <= 1'b1;
          state       <= REQ;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed and randomized bench for fb_pixel_writer against a frame-address reference model.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int          H     = 16;
  localparam int          V     = 8;
  localparam int          NPIX  = H * V;
  localparam int          NW    = NPIX / 2;
  localparam logic [25:0] BASE  = 26'h40;

  logic        clk_100mhz = 1'b0;
  logic        n_reset = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [7:0]  pix_data_i = '0;
  logic        pix_sof_i = 1'b0;
  logic        ram_cs_o;
  logic        ram_rnw_o;
  logic [25:0] ram_addr_o;
  logic [15:0] ram_wdata_o;
  logic        ram_ready_i = 1'b0;
  logic        busy_o;
  logic        frame_done_o;
`ifdef FB_CLEAR_EN
  logic        clear_i = 1'b0;
  logic [7:0]  clear_color_i = '0;
`endif

  fb_pixel_writer #(
    .H_RES (H), .V_RES (V), .BASE_ADDR (BASE), .FIFO_DEPTH (8)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .n_reset      (n_reset),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .pix_data_i   (pix_data_i),
    .pix_sof_i    (pix_sof_i),
    .ram_cs_o     (ram_cs_o),
    .ram_rnw_o    (ram_rnw_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_ready_i  (ram_ready_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
`ifdef FB_CLEAR_EN
    ,
    .clear_i       (clear_i),
    .clear_color_i (clear_color_i)
`endif
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int n_pass = 0;
  int n_checks = 0;
  int n_timeouts = 0;
  int proto_err = 0;
  int done_cnt = 0;
  int lat_fixed = 1;
  bit hold = 1'b0;
  bit spurious = 1'b0;

  // Reference model: frame index and half-word, expected {addr,data,last} words.
  int          m_idx = 0;
  logic [7:0]  m_half = '0;
  logic [42:0] exp_q[$];
  logic [41:0] obs_q[$];
  int          done_at[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic void model_accept(input logic [7:0] d, input logic sof);
    logic [25:0] a;
    if (sof) m_idx = 0;
    if (m_idx % 2 == 0) begin
      m_half = d;
    end else begin
      a = BASE + 26'(m_idx / 2);
      exp_q.push_back({a, d, m_half, (m_idx == NPIX - 1)});
    end
    m_idx = (m_idx + 1) % NPIX;
  endfunction

  // PSRAM responder and protocol monitor, all sampling on the falling edge.
  initial begin : responder
    int age;
    int low_run;
    int cur_lat;
    logic [25:0] pa;
    logic [15:0] pd;
    logic pcs;
    bit seen_req;
    age = 0; low_run = 0; cur_lat = 1; pa = '0; pd = '0; pcs = 1'b0; seen_req = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (!n_reset) begin
        ram_ready_i = 1'b0; age = 0; low_run = 0; pcs = 1'b0; seen_req = 1'b0;
        continue;
      end
      if (ram_rnw_o !== 1'b0) proto_err++;
      if (frame_done_o === 1'b1) begin
        done_cnt++;
        done_at.push_back(obs_q.size());
      end
      if (ram_cs_o === 1'b1) begin
        if (pcs && (ram_addr_o !== pa || ram_wdata_o !== pd)) proto_err++;
        if (!pcs) begin
          if (seen_req && low_run < 2) proto_err++;
          seen_req = 1'b1;
          cur_lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
          age = 0;
        end
        age++;
        low_run = 0;
        if (!hold && age >= cur_lat && !ram_ready_i) begin
          ram_ready_i = 1'b1;
          obs_q.push_back({ram_addr_o, ram_wdata_o});
        end else begin
          ram_ready_i = 1'b0;
        end
      end else begin
        age = 0;
        low_run++;
        ram_ready_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      pa = ram_addr_o; pd = ram_wdata_o; pcs = ram_cs_o;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Called on a falling edge; returns on a falling edge.
  task automatic send_pix(input logic [7:0] d, input logic sof, input int max_wait, output bit ok);
    ok = 1'b0;
    pix_valid_i = 1'b1; pix_data_i = d; pix_sof_i = sof;
    for (int w = 0; w < max_wait; w++) begin
      if (pix_ready_o === 1'b1) begin
        @(posedge clk_100mhz);
        model_accept(d, sof);
        ok = 1'b1;
        break;
      end
      @(negedge clk_100mhz);
    end
    if (ok) @(negedge clk_100mhz);
    pix_valid_i = 1'b0; pix_sof_i = 1'b0;
  endtask

  task automatic sp(input logic [7:0] d, input logic sof);
    bit ok;
    send_pix(d, sof, 300, ok);
    if (!ok) n_timeouts++;
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (busy_o === 1'b0 && ram_cs_o === 1'b0) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk_100mhz);
    end
    if (!idle) n_timeouts++;
    repeat (3) @(negedge clk_100mhz);
  endtask

  task automatic compare(input string tag);
    int n;
    int exp_done;
    int exp_at;
    exp_done = 0; exp_at = 0;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, obs_q[i][41:16], exp_q[i][42:17]);
      check({tag, "_data"}, obs_q[i][15:0], exp_q[i][16:1]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i][0]) begin
        exp_done++;
        exp_at = i + 1;
      end
    end
    check({tag, "_frame_done_cnt"}, done_cnt, exp_done);
    if (exp_done == 1 && done_at.size() == 1) check({tag, "_frame_done_pos"}, done_at[0], exp_at);
    obs_q.delete(); exp_q.delete(); done_at.delete(); done_cnt = 0;
  endtask

  initial begin : stimulus
    bit ok;
    int accepted;
    int busy_wait;

    // Reset state
    repeat (3) @(negedge clk_100mhz);
    check("rst_cs", ram_cs_o, 0);
    check("rst_ready", pix_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_addr", ram_addr_o, 0);
    check("rst_wdata", ram_wdata_o, 0);
    check("rst_rnw", ram_rnw_o, 0);
    #2 n_reset = 1'b1;
    #1 check("ready_before_first_clk", pix_ready_o, 0);
    @(posedge clk_100mhz);
    #1 check("ready_after_first_clk", pix_ready_o, 1);
    @(negedge clk_100mhz);

    // Single pair, ready two cycles after cs; push-then-pop latency
    lat_fixed = 2;
    sp(8'h11, 1'b1);
    sp(8'h22, 1'b0);
    check("lat_cs_low_after_push", ram_cs_o, 0);
    @(negedge clk_100mhz);
    check("lat_cs_high", ram_cs_o, 1);
    check("pair_addr", ram_addr_o, BASE);
    check("pair_wdata", ram_wdata_o, 16'h2211);
    check("pair_rnw", ram_rnw_o, 0);
    drain();
    compare("pair");

    // SOF discards a pending half-word
    sp(8'hAA, 1'b1);
    sp(8'hBB, 1'b1);
    sp(8'hCC, 1'b0);
    drain();
    compare("sof_drop");

    // Full frame plus wrap into the next frame without SOF
    lat_fixed = 1;
    for (int i = 0; i < NPIX + 2; i++) sp(8'($urandom), (i == 0));
    drain();
    compare("frame");

    // Withheld ready: FIFO fills and back-pressures, nothing lost after release
    hold = 1'b1;
    accepted = 0;
    for (int i = 0; i < 30; i++) begin
      send_pix(8'($urandom), (i == 0), 10, ok);
      if (!ok) break;
      accepted++;
    end
    check("hold_accepted_pixels", accepted, 18);
    check("hold_ready_low", pix_ready_o, 0);
    check("hold_busy", busy_o, 1);
    repeat (12) @(negedge clk_100mhz);
    hold = 1'b0;
    for (int i = 0; i < 30; i++) sp(8'($urandom), 1'b0);
    drain();
    compare("hold");

    // Random stream, random ready latency, stray ready strobes between requests
    lat_fixed = 0;
    spurious = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sp(8'($urandom), (i == 0) || ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk_100mhz);
    end
    drain();
    spurious = 1'b0;
    compare("random");

    // Reset asserted while a request is outstanding
    lat_fixed = 1;
    hold = 1'b1;
    sp(8'h33, 1'b1);
    sp(8'h44, 1'b0);
    busy_wait = 0;
    while (ram_cs_o !== 1'b1 && busy_wait < 20) begin
      @(negedge clk_100mhz);
      busy_wait++;
    end
    check("mid_req_cs_high", ram_cs_o, 1);
    #2 n_reset = 1'b0;
    #1 check("mid_req_cs_drop", ram_cs_o, 0);
    check("mid_req_busy_drop", busy_o, 0);
    check("mid_req_ready_drop", pix_ready_o, 0);
    repeat (2) @(negedge clk_100mhz);
    obs_q.delete(); exp_q.delete(); done_at.delete(); done_cnt = 0;
    m_idx = 0; m_half = '0;
    hold = 1'b0;
    #2 n_reset = 1'b1;
    @(negedge clk_100mhz);
    @(negedge clk_100mhz);
    sp(8'h5A, 1'b1);
    sp(8'hA5, 1'b0);
    sp(8'h01, 1'b0);
    sp(8'h02, 1'b0);
    drain();
    compare("after_reset");

`ifdef FB_CLEAR_EN
    // Frame clear, starting from a half-finished pixel position
    sp(8'h07, 1'b1);
    sp(8'h08, 1'b0);
    sp(8'h09, 1'b0);
    drain();
    compare("pre_clear");
    m_idx = 0; m_half = '0;
    for (int i = 0; i < NW; i++) exp_q.push_back({BASE + 26'(i), 16'hE0E0, (i == NW - 1)});
    clear_color_i = 8'hE0;
    clear_i = 1'b1;
    busy_wait = 0;
    while (busy_o !== 1'b1 && busy_wait < 10) begin
      @(negedge clk_100mhz);
      busy_wait++;
    end
    clear_i = 1'b0;
    accepted = 0;
    busy_wait = 0;
    while (busy_o === 1'b1 && busy_wait < 5000) begin
      if (pix_ready_o !== 1'b0) accepted++;
      @(negedge clk_100mhz);
      busy_wait++;
    end
    check("clear_ready_low_cycles", accepted, 0);
    drain();
    compare("clear");
    sp(8'h61, 1'b0);
    sp(8'h62, 1'b0);
    drain();
    compare("post_clear_index");
`endif

    check("protocol_errors", proto_err, 0);
    check("accept_or_drain_timeouts", n_timeouts, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
